toggle_cover_collector: RTL and testbench

- Upstream feeder for the per-module toggle-coverage reporter, which consumes a WIDTH-bit `valid` vector and emits one coverage event per asserted bit.
- Watches a WIDTH-bit design signal and tracks, per bit, whether a rising edge and a falling edge have both been observed since reset or clear.
- Emits a one-cycle `valid` pulse on a bit the first time that bit becomes fully toggled, so each point is reported once.
- Keeps a running covered count and an all-covered flag for the harness.

---
 rtl/toggle_cover_pkg.sv | 12 +
 rtl/toggle_cover_bit.sv | 47 ++++
 rtl/toggle_cover_collector.sv | 63 ++++++
 tb/tb_toggle_cover_collector.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle-coverage collector: default width and the
// helper that sizes the covered-bit counter.
package toggle_cover_pkg;

  localparam int TCC_DEFAULT_WIDTH = 36;

  // Enough bits to hold every value from 0 to w inclusive.
  function automatic int tcc_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// One monitored bit: baseline flop, sticky rise/fall flags and the
// registered first-covered pulse.
module toggle_cover_bit (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  input  logic armed,
  input  logic clear,
  input  logic sig_bit,
  output logic new_cov,
  output logic valid
);

  logic prev_q;
  logic seen_rise_q;
  logic seen_fall_q;
  logic rise;
  logic fall;
  logic next_rise;
  logic next_fall;

  // Transitions only count once a baseline exists; clear discards this edge's.
  always_comb begin
    rise      = sample & armed & sig_bit & ~prev_q;
    fall      = sample & armed & ~sig_bit & prev_q;
    next_rise = clear ? 1'b0 : (seen_rise_q | rise);
    next_fall = clear ? 1'b0 : (seen_fall_q | fall);
    new_cov   = next_rise & next_fall & ~(seen_rise_q & seen_fall_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q      <= 1'b0;
      seen_rise_q <= 1'b0;
      seen_fall_q <= 1'b0;
      valid       <= 1'b0;
    end else begin
      if (sample) begin
        prev_q <= sig_bit;
      end
      seen_rise_q <= next_rise;
      seen_fall_q <= next_fall;
      valid       <= new_cov;
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Per-bit toggle-coverage tracker feeding the coverage reporter: one-shot
// valid pulse per newly covered bit, running count and all-covered flag.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = TCC_DEFAULT_WIDTH,
  parameter int CNT_W = tcc_cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam logic [0:0] UNARMED = 1'b0;
  localparam logic [0:0] ARMED   = 1'b1;

  logic [0:0]       armed_q;
  logic [WIDTH-1:0] new_cov;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] count_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_cover_bit u_bit (
      .clock   (clock),
      .reset   (reset),
      .sample  (sample_en),
      .armed   (armed_q == ARMED),
      .clear   (clear),
      .sig_bit (sig[i]),
      .new_cov (new_cov[i]),
      .valid   (valid[i])
    );
  end

  // Count can never exceed WIDTH, so the sum needs no saturation.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(new_cov[i]);
    end
    count_next = clear ? '0 : (covered_count + pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_q       <= UNARMED;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      if (sample_en) begin
        armed_q <= ARMED;
      end
      covered_count <= count_next;
      all_covered   <= (count_next == CNT_W'(WIDTH));
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed-vector bench for toggle_cover_collector with hand-computed
// expectations.
module tb_toggle_cover_collector;

  localparam int W  = 36;
  localparam int CW = 6;

  logic          clock;
  logic          reset;
  logic          sample_en;
  logic          clear;
  logic [W-1:0]  sig;
  logic [W-1:0]  valid;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int n_checks = 0;
  int n_pass   = 0;

  toggle_cover_collector #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .sample_en     (sample_en),
    .clear         (clear),
    .sig           (sig),
    .valid         (valid),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic [W-1:0] s, input logic en, input logic clr);
    @(negedge clock);
    sig       = s;
    sample_en = en;
    clear     = clr;
    @(posedge clock);
    #1;
  endtask

  // Pulse reset inside a cycle, away from any clock edge.
  task automatic pulse_reset();
    sample_en = 1'b0;
    clear     = 1'b0;
    #2 reset = 1'b1;
    #3 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    clear     = 1'b0;
    sig       = '0;
    #3;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_count", 64'(covered_count), 64'd0);
    chk("rst_all", 64'(all_covered), 64'd0);
    #4 reset = 1'b0;

    // Baseline sample is not counted
    step(36'hF_FFFF_FFFF, 1'b1, 1'b0);
    chk("base_valid", 64'(valid), 64'h0);
    chk("base_count", 64'(covered_count), 64'd0);
    chk("base_armed", 64'(dut.armed_q), 64'd1);

    // Single bit 0 -> 1 -> 0
    pulse_reset();
    step(36'h0, 1'b1, 1'b0);
    step(36'h1, 1'b1, 1'b0);
    chk("single_mid_valid", 64'(valid), 64'h0);
    step(36'h0, 1'b1, 1'b0);
    chk("single_valid", 64'(valid), 64'h1);
    chk("single_count", 64'(covered_count), 64'd1);
    step(36'h0, 1'b1, 1'b0);
    chk("single_one_cycle", 64'(valid), 64'h0);
    step(36'h1, 1'b1, 1'b0);
    step(36'h0, 1'b1, 1'b0);
    chk("single_repeat_a", 64'(valid), 64'h0);
    step(36'h1, 1'b1, 1'b0);
    chk("single_repeat_b", 64'(valid), 64'h0);
    chk("single_repeat_count", 64'(covered_count), 64'd1);

    // Bulk completion
    pulse_reset();
    step(36'h0, 1'b1, 1'b0);
    step(36'hF_FFFF_FFFF, 1'b1, 1'b0);
    chk("bulk_mid_valid", 64'(valid), 64'h0);
    step(36'h0, 1'b1, 1'b0);
    chk("bulk_valid", 64'(valid), 64'hF_FFFF_FFFF);
    chk("bulk_count", 64'(covered_count), 64'd36);
    chk("bulk_all", 64'(all_covered), 64'd1);
    step(36'h0, 1'b1, 1'b0);
    chk("bulk_valid_drop", 64'(valid), 64'h0);
    chk("bulk_all_hold", 64'(all_covered), 64'd1);

    // Enable gaps are not transitions
    pulse_reset();
    step(36'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(36'h1, 1'b0, 1'b0);
    chk("gap_valid_in_gap", 64'(valid), 64'h0);
    step(36'h0, 1'b1, 1'b0);
    chk("gap_valid", 64'(valid), 64'h0);
    chk("gap_count", 64'(covered_count), 64'd0);
    step(36'h1, 1'b1, 1'b0);
    step(36'h0, 1'b1, 1'b0);
    chk("gap_after_valid", 64'(valid), 64'h1);
    chk("gap_after_count", 64'(covered_count), 64'd1);

    // Clear beats a simultaneous fall
    pulse_reset();
    step(36'h0, 1'b1, 1'b0);
    step(36'h8, 1'b1, 1'b0);
    step(36'h0, 1'b1, 1'b1);
    chk("clr_valid", 64'(valid), 64'h0);
    chk("clr_count", 64'(covered_count), 64'd0);
    step(36'h8, 1'b1, 1'b0);
    step(36'h0, 1'b1, 1'b0);
    chk("clr_after_valid", 64'(valid), 64'h8);
    chk("clr_after_count", 64'(covered_count), 64'd1);

    // Async reset mid-run
    pulse_reset();
    step(36'h0, 1'b1, 1'b0);
    step(36'h7F, 1'b1, 1'b0);
    step(36'h0, 1'b1, 1'b0);
    chk("ar_pre_valid", 64'(valid), 64'h7F);
    chk("ar_pre_count", 64'(covered_count), 64'd7);
    sample_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(valid), 64'h0);
    chk("ar_count", 64'(covered_count), 64'd0);
    chk("ar_all", 64'(all_covered), 64'd0);
    chk("ar_armed", 64'(dut.armed_q), 64'd0);
    #1 reset = 1'b0;
    step(36'h7F, 1'b1, 1'b0);
    chk("ar_base_valid", 64'(valid), 64'h0);
    step(36'h0, 1'b1, 1'b0);
    chk("ar_fall_only_valid", 64'(valid), 64'h0);
    chk("ar_fall_only_count", 64'(covered_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
